// File: rtl/mem_wb_stage.sv
// Memory-stage responder with wait-stated doubleword data memory and MEM/WB register.
// Raises Stall while an access waits; the stalled instruction writes back exactly once.
module mem_wb_stage #(
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  WB,
    input  logic        Branch,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        ALU_Zero,
    input  logic [63:0] Adder_Result,
    input  logic [63:0] ALU_Result,
    input  logic [63:0] Write_Data,
    input  logic [4:0]  rd,
    output logic        Stall,
    output logic        PCSrc,
    output logic [63:0] Branch_Target,
    output logic [1:0]  WB_Out,
    output logic [63:0] Read_Data_Out,
    output logic [63:0] ALU_Result_Out,
    output logic [4:0]  rd_out,
    output logic        Misaligned_Out
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

    logic [63:0]   mem [DEPTH];
    logic [3:0]    cnt;
    logic          memop;
    logic          commit;
    logic [AW-1:0] idx;

    logic [1:0]    wb_p1;
    logic [63:0]   rdata_p1;
    logic [63:0]   alu_p1;
    logic [4:0]    rd_p1;
    logic          mis_p1;

    assign memop  = MemRead | MemWrite;
    assign commit = memop && (cnt == WAIT_L);
    assign idx    = ALU_Result[AW+2:3];

    assign Stall         = memop && !commit;
    assign PCSrc         = Branch & ALU_Zero;
    assign Branch_Target = Adder_Result;

    // Wait-state counter: restarts from 0 after every commit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (Stall) begin
            cnt <= cnt + 4'd1;
        end else begin
            cnt <= '0;
        end
    end

    // Data memory is not reset; a store caught by reset is dropped
    always_ff @(posedge clk) begin
        if (reset_n && commit && MemWrite) begin
            mem[idx] <= Write_Data;
        end
    end

    // MEM/WB register: bubble while stalled, capture on commit or non-memop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_p1    <= '0;
            rdata_p1 <= '0;
            alu_p1   <= '0;
            rd_p1    <= '0;
            mis_p1   <= 1'b0;
        end else if (Stall) begin
            wb_p1    <= '0;
            rdata_p1 <= '0;
            alu_p1   <= '0;
            rd_p1    <= '0;
            mis_p1   <= 1'b0;
        end else begin
            wb_p1    <= WB;
            alu_p1   <= ALU_Result;
            rd_p1    <= rd;
            mis_p1   <= memop && (ALU_Result[2:0] != 3'd0);
            rdata_p1 <= (MemRead && !MemWrite) ? mem[idx] : 64'd0;
        end
    end

    assign WB_Out         = wb_p1;
    assign Read_Data_Out  = rdata_p1;
    assign ALU_Result_Out = alu_p1;
    assign rd_out         = rd_p1;
    assign Misaligned_Out = mis_p1;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: one instance with two wait states, one with none.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  WB;
    logic        Branch, MemWrite, MemRead, ALU_Zero;
    logic [63:0] Adder_Result, ALU_Result, Write_Data;
    logic [4:0]  rd;

    logic        stall2, pcsrc2, mis2;
    logic [63:0] bt2, rdata2, alu2;
    logic [1:0]  wb2;
    logic [4:0]  rd2;

    logic        stall0, pcsrc0, mis0;
    logic [63:0] bt0, rdata0, alu0;
    logic [1:0]  wb0;
    logic [4:0]  rd0;

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DEPTH(128), .WAIT_CYCLES(2)) u2 (
        .clk(clk), .reset_n(reset_n), .WB(WB), .Branch(Branch), .MemWrite(MemWrite),
        .MemRead(MemRead), .ALU_Zero(ALU_Zero), .Adder_Result(Adder_Result),
        .ALU_Result(ALU_Result), .Write_Data(Write_Data), .rd(rd),
        .Stall(stall2), .PCSrc(pcsrc2), .Branch_Target(bt2), .WB_Out(wb2),
        .Read_Data_Out(rdata2), .ALU_Result_Out(alu2), .rd_out(rd2), .Misaligned_Out(mis2)
    );

    mem_wb_stage #(.DEPTH(128), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .reset_n(reset_n), .WB(WB), .Branch(Branch), .MemWrite(MemWrite),
        .MemRead(MemRead), .ALU_Zero(ALU_Zero), .Adder_Result(Adder_Result),
        .ALU_Result(ALU_Result), .Write_Data(Write_Data), .rd(rd),
        .Stall(stall0), .PCSrc(pcsrc0), .Branch_Target(bt0), .WB_Out(wb0),
        .Read_Data_Out(rdata0), .ALU_Result_Out(alu0), .rd_out(rd0), .Misaligned_Out(mis0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rd_en, input logic wr_en, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [4:0] rdv, input logic [1:0] wbv);
        MemRead    = rd_en;
        MemWrite   = wr_en;
        ALU_Result = addr;
        Write_Data = wdata;
        rd         = rdv;
        WB         = wbv;
        Branch     = 1'b0;
        ALU_Zero   = 1'b0;
    endtask

    // Full access on the two-wait-state instance: two stall cycles, then commit edge
    task automatic memop2(input string tag, input logic rd_en, input logic wr_en,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [4:0] rdv, input logic [1:0] wbv);
        set_in(rd_en, wr_en, addr, wdata, rdv, wbv);
        #1;
        chk({tag, "_stall_c0"}, 64'(stall2), 64'd1);
        tick();
        chk({tag, "_stall_c1"}, 64'(stall2), 64'd1);
        chk({tag, "_bubble_wb"}, 64'(wb2), 64'd0);
        chk({tag, "_bubble_rd"}, 64'(rd2), 64'd0);
        tick();
        chk({tag, "_stall_c2"}, 64'(stall2), 64'd0);
        tick();
    endtask

    initial begin
        reset_n      = 1'b0;
        Adder_Result = '0;
        set_in(1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 2'b00);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Non-memop stream
        set_in(1'b0, 1'b0, 64'd7, 64'd0, 5'd3, 2'b10);
        #1;
        chk("alu_stall", 64'(stall2), 64'd0);
        tick();
        chk("alu_result", alu2, 64'd7);
        chk("alu_rd", 64'(rd2), 64'd3);
        chk("alu_wb", 64'(wb2), 64'd2);
        chk("alu_stall_after", 64'(stall2), 64'd0);

        // Mid-simulation reset clears registered outputs asynchronously
        set_in(1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 2'b00);
        reset_n = 1'b0;
        #1;
        chk("rst_wb", 64'(wb2), 64'd0);
        chk("rst_alu", alu2, 64'd0);
        chk("rst_rd", 64'(rd2), 64'd0);
        chk("rst_rdata", rdata2, 64'd0);
        chk("rst_mis", 64'(mis2), 64'd0);
        chk("rst_stall", 64'(stall2), 64'd0);
        chk("rst0_alu", alu0, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Store then load
        memop2("st40", 1'b0, 1'b1, 64'h40, 64'hDEADBEEF_00C0FFEE, 5'd0, 2'b00);
        chk("st40_wb", 64'(wb2), 64'd0);
        chk("st40_rdata", rdata2, 64'd0);
        chk("st40_alu", alu2, 64'h40);
        memop2("ld40", 1'b1, 1'b0, 64'h40, 64'd0, 5'd5, 2'b11);
        chk("ld40_rdata", rdata2, 64'hDEADBEEF_00C0FFEE);
        chk("ld40_rd", 64'(rd2), 64'd5);
        chk("ld40_wb", 64'(wb2), 64'd3);
        chk("ld40_mis", 64'(mis2), 64'd0);

        // Read and write both high behaves as a store
        memop2("rw48", 1'b1, 1'b1, 64'h48, 64'h1234, 5'd6, 2'b10);
        chk("rw48_rdata", rdata2, 64'd0);
        memop2("ld48", 1'b1, 1'b0, 64'h48, 64'd0, 5'd6, 2'b11);
        chk("ld48_rdata", rdata2, 64'h1234);

        // Branch resolution is combinational and independent of Stall
        set_in(1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 2'b00);
        Branch       = 1'b1;
        ALU_Zero     = 1'b1;
        Adder_Result = 64'h100;
        #1;
        chk("br_pcsrc", 64'(pcsrc2), 64'd1);
        chk("br_target", bt2, 64'h100);
        chk("br_stall", 64'(stall2), 64'd0);
        ALU_Zero = 1'b0;
        #1;
        chk("br_pcsrc_nz", 64'(pcsrc2), 64'd0);
        tick();

        // Address wrap and misaligned access: 0x408 and 0x00C both hit index 1
        memop2("st408", 1'b0, 1'b1, 64'h408, 64'h11, 5'd0, 2'b00);
        chk("st408_mis", 64'(mis2), 64'd0);
        memop2("ld00c", 1'b1, 1'b0, 64'h00C, 64'd0, 5'd4, 2'b11);
        chk("ld00c_rdata", rdata2, 64'h11);
        chk("ld00c_mis", 64'(mis2), 64'd1);

        // Reset in the second stall cycle drops the pending store
        memop2("st80a", 1'b0, 1'b1, 64'h80, 64'hAAAA_5555, 5'd0, 2'b00);
        set_in(1'b0, 1'b1, 64'h80, 64'hBBBB_0000, 5'd0, 2'b00);
        #1;
        chk("st80b_stall_c0", 64'(stall2), 64'd1);
        tick();
        chk("st80b_stall_c1", 64'(stall2), 64'd1);
        reset_n = 1'b0;
        tick();
        set_in(1'b1, 1'b0, 64'h80, 64'd0, 5'd9, 2'b10);
        reset_n = 1'b1;
        memop2("ld80", 1'b1, 1'b0, 64'h80, 64'd0, 5'd9, 2'b10);
        chk("ld80_rdata", rdata2, 64'hAAAA_5555);
        chk("ld80_rd", 64'(rd2), 64'd9);

        // Zero wait states: no stall, single-edge access
        set_in(1'b0, 1'b1, 64'h80, 64'hC0DE_F00D, 5'd0, 2'b00);
        #1;
        chk("w0_st_stall", 64'(stall0), 64'd0);
        tick();
        chk("w0_st_rdata", rdata0, 64'd0);
        set_in(1'b1, 1'b0, 64'h80, 64'd0, 5'd12, 2'b11);
        #1;
        chk("w0_ld_stall", 64'(stall0), 64'd0);
        tick();
        chk("w0_ld_rdata", rdata0, 64'hC0DE_F00D);
        chk("w0_ld_rd", 64'(rd0), 64'd12);
        chk("w0_ld_wb", 64'(wb0), 64'd3);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-stage responder and MEM/WB pipeline register for the 64-bit five-stage pipeline. It consumes the control and data fields registered by the EX/MEM stage, resolves the branch decision, and services loads and stores against an internal doubleword data memory with a configurable wait-state count. While an access is in progress it raises `Stall` to freeze the upstream stages. It then delivers the writeback fields to the WB stage.

## Interface
- `DEPTH`, 128: data memory size in 64-bit doublewords; power of two.
- `WAIT_CYCLES`, 2: wait states per memory access, range 0–15.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `WB` input 2: writeback control from EX/MEM, as `{RegWrite, MemtoReg}`.
- `Branch`, `MemWrite`, `MemRead` input 1 each: memory-stage control from EX/MEM.
- `ALU_Zero` input 1: zero flag from EX/MEM.
- `Adder_Result` input 64: branch target from EX/MEM.
- `ALU_Result` input 64: byte address for memory operations, or the result for non-memory operations.
- `Write_Data` input 64: store data, which is the forwarded rs2 value.
- `rd` input 5: destination register.
- `Stall` output 1: combinational; holds PC, IF/ID, ID/EX and EX/MEM.
- `PCSrc` output 1: combinational, equal to `Branch & ALU_Zero`.
- `Branch_Target` output 64: combinational, equal to `Adder_Result`.
- `WB_Out` output 2: registered.
- `Read_Data_Out` output 64: registered.
- `ALU_Result_Out` output 64: registered.
- `rd_out` output 5: registered.
- `Misaligned_Out` output 1: registered.

## Operation
- **Memory operation (memop):** defined as `MemRead | MemWrite`.
- **Index:** `ALU_Result[log2(DEPTH)+2:3]`.
  - Upper address bits are ignored, so addresses wrap modulo `DEPTH*8`.
  - Low 3 bits are ignored for the access.
- **Misaligned flag:** `Misaligned_Out` is registered as `memop & (ALU_Result[2:0] != 0)` when the instruction commits.
- **Wait counter:** `cnt`, 4 bits.
  - IDLE when `cnt` = 0; WAIT when `cnt` is 1 to `WAIT_CYCLES`.
  - If memop and `cnt` != `WAIT_CYCLES`: `Stall` = 1, and `cnt` increments at the clock edge.
  - If memop and `cnt` == `WAIT_CYCLES`: `Stall` = 0. At the clock edge the access commits and `cnt` returns to 0.
  - If no memop: `Stall` = 0 and `cnt` stays 0.
- **Commit of a store:** `mem[index]` is written with `Write_Data`. `Read_Data_Out` loads 0.
- **Commit of a load:** `Read_Data_Out` loads `mem[index]`.
- **`MemRead` and `MemWrite` both high:** treated as a store; `Read_Data_Out` loads 0.
- **Commit register load:** on every commit, and on every edge with no memop:
  - `WB_Out` loads `WB`.
  - `ALU_Result_Out` loads `ALU_Result`.
  - `rd_out` loads `rd`.
- **Bubble during stall:** on every edge where `Stall` = 1, MEM/WB loads a bubble so the stalled instruction is written back exactly once. A bubble sets `WB_Out` = 0, `rd_out` = 0, `Read_Data_Out` = 0, `ALU_Result_Out` = 0 and `Misaligned_Out` = 0.
- **Combinational outputs:** `PCSrc` and `Branch_Target` are purely combinational and are never gated by `Stall`. Branches are never memops.
- **Memory contents:** not affected by reset. The bench writes a location before reading it.

## Timing
- **Reset:** `reset_n` low asynchronously clears:
  - `cnt` to 0.
  - `WB_Out`, `Read_Data_Out`, `ALU_Result_Out`, `rd_out` and `Misaligned_Out` to 0.
- **Reset in the middle of an access:** the pending store is dropped, with no memory write. After reset is released, a memop still present on the inputs starts again from `cnt` = 0.
- **Memop latency:**
  - A memop presented in cycle t holds `Stall` high for cycles t to t+`WAIT_CYCLES`−1.
  - `Stall` is low in cycle t+`WAIT_CYCLES`.
  - Results appear on the MEM/WB outputs after the edge that ends cycle t+`WAIT_CYCLES`.
- **`WAIT_CYCLES` = 0:** `Stall` never asserts and the block behaves as a plain register with a single-cycle memory.
- **Non-memop latency:** 1 cycle, with no stall.
- **Back-to-back memops:** each memop incurs the full `WAIT_CYCLES` stall, because `cnt` restarts from 0 after every commit.
- **Input stability:** inputs are stable while `Stall` = 1, since EX/MEM is held. The block does not re-sample or re-check them mid-wait.

## Test plan
All scenarios use `WAIT_CYCLES` = 2 unless stated otherwise.

1. **Reset:** assert `reset_n` = 0 mid-simulation.
   - All registered outputs read 0.
   - `Stall` = 0 with no memop on the inputs.
2. **Store then load:**
   - Store 0xDEADBEEF_00C0FFEE to address 0x40: `Stall` is high for 2 cycles, then `WB_Out` is a bubble.
   - Load from address 0x40 with `rd` = 5 and `WB` = 2'b11: `Stall` is high for 2 cycles. After the third edge, `Read_Data_Out` = 0xDEADBEEF_00C0FFEE, `rd_out` = 5 and `WB_Out` = 2'b11.
3. **Non-memop stream:** present an ALU op with `ALU_Result` = 7 and `rd` = 3.
   - The next edge gives `ALU_Result_Out` = 7 and `rd_out` = 3.
   - `Stall` never rises.
4. **Branch:** `Branch` = 1, `ALU_Zero` = 1, `Adder_Result` = 0x100.
   - `PCSrc` = 1 and `Branch_Target` = 0x100 in the same cycle.
   - With `ALU_Zero` = 0, `PCSrc` = 0.
5. **Wrap and misaligned access:** with `DEPTH` = 128, store 0x11 to address 0x408 and then load from address 0x00C.
   - The load returns 0x11, because 0x408 wraps to index 1 and 0x00C also maps to index 1.
   - `Misaligned_Out` = 1 on the load.
6. **Reset mid-wait and zero wait states:**
   - Assert `reset_n` low in the second stall cycle of a store to address 0x80, then reload address 0x80. The old contents are returned.
   - Repeat with `WAIT_CYCLES` = 0: there is no stall and the load data appears after 1 edge.
